// File: rtl/psdsquare_pkg.sv
// psdsquare_pkg: fixed-point format shared by psdsquare and the square-root unit.
// Holds the FSM state type, default widths and the rounding constant.
package psdsquare_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      ROUND
   } state_t;

   localparam int NBITS_DEF   = 32;
   localparam int DECIMAL_DEF = 4;

   // operand width and full product width
   localparam int N_DEF = NBITS_DEF / 2 + DECIMAL_DEF;
   localparam int P_DEF = NBITS_DEF + 2 * DECIMAL_DEF;

   // half an LSB of the integer result, in product units
   localparam longint RND_DEF = 64'(1) << (2 * DECIMAL_DEF - 1);

   function automatic longint rnd_const(input int dec);
      return 64'(1) << (2 * dec - 1);
   endfunction

endpackage

// File: rtl/psdsquare_round.sv
// psdsquare_round: reduces the P-bit product to the NBITS integer square.
// Build option PSDSQUARE_ROUND_EN selects round-to-nearest, else floor.
module psdsquare_round
   import psdsquare_pkg::*;
#(
   parameter int NBITS   = NBITS_DEF,
   parameter int DECIMAL = DECIMAL_DEF
) (
   input  logic [NBITS+2*DECIMAL-1:0] acc,
   output logic [NBITS-1:0]           sq
);

   localparam int P = NBITS + 2 * DECIMAL;
   localparam int F = 2 * DECIMAL;

`ifdef PSDSQUARE_ROUND_EN
   localparam logic [P:0] RND = (P+1)'(rnd_const(DECIMAL));

   logic [P:0] sum;
   logic       unused_rnd;

   // add half an LSB before dropping the fraction; ties cannot occur
   always_comb begin
      sum = {1'b0, acc} + RND;
      sq = sum[F +: NBITS];
   end

   assign unused_rnd = ^{sum[P], sum[F-1:0]};
`else
   logic unused_frac;

   // floor: the fraction bits are simply discarded
   always_comb begin
      sq = acc[F +: NBITS];
   end

   assign unused_frac = ^acc[F-1:0];
`endif

endmodule

// File: rtl/psdsquare.sv
// psdsquare: sequential shift-add fixed-point squarer, one multiplier bit per clock.
// Build option PSDSQUARE_ROUND_EN: round-to-nearest result (default floor).
module psdsquare
   import psdsquare_pkg::*;
#(
   parameter int NBITS   = NBITS_DEF,
   parameter int DECIMAL = DECIMAL_DEF
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       start,
   input  logic [NBITS/2+DECIMAL-1:0] xin,
   output logic                       busy,
   output logic                       done,
   output logic [NBITS-1:0]           sq
);

   localparam int N     = NBITS / 2 + DECIMAL;
   localparam int P     = NBITS + 2 * DECIMAL;
   localparam int CNT_W = $clog2(N);

   state_t           state_q, state_d;
   logic [P-1:0]     acc_q, acc_d;
   logic [P-1:0]     mcand_q, mcand_d;
   logic [N-1:0]     mplier_q, mplier_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_d;
   logic             done_d;
   logic [NBITS-1:0] sq_d;
   logic [NBITS-1:0] sq_rnd;

   psdsquare_round #(
      .NBITS   (NBITS),
      .DECIMAL (DECIMAL)
   ) u_round (
      .acc (acc_q),
      .sq  (sq_rnd)
   );

   // next-state, datapath and registered-output values
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      busy_d   = busy;
      done_d   = 1'b0;
      sq_d     = sq;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               mcand_d  = P'(xin);
               mplier_d = xin;
               acc_d    = '0;
               cnt_d    = CNT_W'(N - 1);
               busy_d   = 1'b1;
               state_d  = CALC;
            end
         end
         CALC: begin
            // multiplicand pre-shifted each step instead of barrel shift
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            if (cnt_q == '0) begin
               state_d = ROUND;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ROUND: begin
            sq_d    = sq_rnd;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // state, datapath and output registers; reset discards any operation
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         sq       <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         busy     <= busy_d;
         done     <= done_d;
         sq       <= sq_d;
      end
   end

endmodule

// File: tb/tb_psdsquare.sv
// tb_psdsquare: directed self-checking bench for psdsquare.
// Expectations follow PSDSQUARE_ROUND_EN when it is defined.
module tb_psdsquare;

   localparam int LAT = 21;

   logic        clock;
   logic        reset;
   logic        start;
   logic [19:0] xin;
   logic        busy;
   logic        done;
   logic [31:0] sq;

   int n_cmp;
   int n_err;

   psdsquare dut (
      .clock (clock),
      .reset (reset),
      .start (start),
      .xin   (xin),
      .busy  (busy),
      .done  (done),
      .sq    (sq)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // bounded wait for done, sampled 1ns after each rising edge
   task automatic wait_done(input int limit,
                            output int cyc,
                            output bit seen);
      cyc  = 0;
      seen = 1'b0;
      while (cyc < limit && !seen) begin
         @(posedge clock);
         #1;
         cyc++;
         if (done) seen = 1'b1;
      end
   endtask

   // issue one operation and check latency, result and pulse width
   task automatic run_op(input logic [19:0] x,
                         input logic [31:0] exp,
                         input string name);
      int cyc;
      bit seen;
      start = 1'b1;
      xin   = x;
      @(posedge clock);
      #1;
      start = 1'b0;
      xin   = 20'h5A5A5;
      n_cmp++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL %s busy: got %b want 1", name, busy);
      end
      wait_done(LAT + 10, cyc, seen);
      n_cmp++;
      if (!seen || cyc != LAT) begin
         n_err++;
         $display("FAIL %s latency: got %0d seen %b want %0d",
                  name, cyc, seen, LAT);
      end
      n_cmp++;
      if (sq !== exp || busy !== 1'b0) begin
         n_err++;
         $display("FAIL %s sq: got %h busy %b want %h busy 0",
                  name, sq, busy, exp);
      end
      @(posedge clock);
      #1;
      n_cmp++;
      if (done !== 1'b0 || sq !== exp) begin
         n_err++;
         $display("FAIL %s hold: got done %b sq %h want 0 %h",
                  name, done, sq, exp);
      end
   endtask

   task automatic test_reset();
      start = 1'b0;
      xin   = '0;
      reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      n_cmp++;
      if ({busy, done, sq} !== 34'd0) begin
         n_err++;
         $display("FAIL reset: got busy %b done %b sq %h want 0",
                  busy, done, sq);
      end
      reset = 1'b1;
      repeat (5) @(posedge clock);
      #1;
      n_cmp++;
      if ({busy, done, sq} !== 34'd0) begin
         n_err++;
         $display("FAIL idle: got busy %b done %b sq %h want 0",
                  busy, done, sq);
      end
   endtask

   task automatic test_basic();
      run_op(20'h00030, 32'd9, "sq3p0");
      run_op(20'h00028, 32'd6, "sq2p5");
`ifdef PSDSQUARE_ROUND_EN
      run_op(20'h0001B, 32'd3, "sq1p6875");
`else
      run_op(20'h0001B, 32'd2, "sq1p6875");
`endif
   endtask

   task automatic test_boundary();
      run_op(20'hFFFFF, 32'hFFFFE000, "max");
      run_op(20'h00000, 32'd0, "zero");
   endtask

   task automatic test_start_ignored();
      int cyc;
      bit seen;
      start = 1'b1;
      xin   = 20'h00030;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clock);
      #1;
      start = 1'b1;
      xin   = 20'h00028;
      @(posedge clock);
      #1;
      start = 1'b0;
      wait_done(LAT, cyc, seen);
      n_cmp++;
      if (!seen || cyc != LAT - 6) begin
         n_err++;
         $display("FAIL ign latency: got %0d seen %b want %0d",
                  cyc, seen, LAT - 6);
      end
      n_cmp++;
      if (sq !== 32'd9) begin
         n_err++;
         $display("FAIL ign sq: got %h want 9", sq);
      end
      wait_done(LAT + 4, cyc, seen);
      n_cmp++;
      if (seen) begin
         n_err++;
         $display("FAIL ign extra done: got done after %0d want none",
                  cyc);
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      bit seen;
      start = 1'b1;
      xin   = 20'h00028;
      @(posedge clock);
      #1;
      wait_done(LAT + 10, cyc, seen);
      n_cmp++;
      if (!seen || cyc != LAT || sq !== 32'd6) begin
         n_err++;
         $display("FAIL b2b first: got %0d %b sq %h want %0d 1 6",
                  cyc, seen, sq, LAT);
      end
      xin = 20'h00030;
      @(posedge clock);
      #1;
      start = 1'b0;
      n_cmp++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         n_err++;
         $display("FAIL b2b accept: got busy %b done %b want 1 0",
                  busy, done);
      end
      wait_done(LAT + 10, cyc, seen);
      n_cmp++;
      if (!seen || cyc != LAT || sq !== 32'd9) begin
         n_err++;
         $display("FAIL b2b second: got %0d %b sq %h want %0d 1 9",
                  cyc, seen, sq, LAT);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_async_reset();
      int cyc;
      bit seen;
      start = 1'b1;
      xin   = 20'h00030;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (7) @(posedge clock);
      #3;
      reset = 1'b0;
      #1;
      n_cmp++;
      if ({busy, done, sq} !== 34'd0) begin
         n_err++;
         $display("FAIL async rst: got busy %b done %b sq %h want 0",
                  busy, done, sq);
      end
      @(posedge clock);
      #3;
      reset = 1'b1;
      wait_done(LAT + 10, cyc, seen);
      n_cmp++;
      if (seen || busy !== 1'b0) begin
         n_err++;
         $display("FAIL rst discard: got done %b busy %b want 0 0",
                  seen, busy);
      end
      @(posedge clock);
      #1;
`ifdef PSDSQUARE_ROUND_EN
      run_op(20'h0001B, 32'd3, "post_rst");
`else
      run_op(20'h0001B, 32'd2, "post_rst");
`endif
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b0;
      start = 1'b0;
      xin   = '0;
      test_reset();
      test_basic();
      test_boundary();
      test_start_ignored();
      test_back_to_back();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/psdsquare.md
# psdsquare

Sequential fixed-point squarer: the inverse of the pseudo-digit square-root unit, sharing its NBITS/DECIMAL fixed-point format. It takes an unsigned value with DECIMAL fractional bits and produces the integer square, one multiplier bit per clock (shift-add). The result can be looped back into the square-root unit for self-checking, or serve as a standalone squaring datapath.

## Interface
- NBITS, 32, width of integer result `sq`; input integer part is NBITS/2 bits
- DECIMAL, 4, fractional bits of `xin`; product carries 2*DECIMAL fractional bits
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- xin  input  NBITS/2+DECIMAL  unsigned fixed-point operand, DECIMAL fractional bits
- busy  output  1  high from the edge accepting `start` until the result edge
- done  output  1  one-cycle pulse; `sq` valid from this cycle
- sq  output  NBITS  integer square, held until the next `done`

## Operation
- Let N = NBITS/2+DECIMAL and P = NBITS+2*DECIMAL (full product width).
- States: IDLE, CALC, ROUND.
- IDLE: on `start`=1, latch `xin` into a multiplicand register and a multiplier shift register. Clear the P-bit accumulator and load the bit counter with N-1. Go to CALC.
- CALC, each cycle:
  - If the multiplier LSB is 1, add the multiplicand, shifted left by (N-1-count), to the accumulator.
  - Shift the multiplier right.
  - When the counter reaches 0, go to ROUND. Otherwise decrement the counter.
  - Equivalent shift-right formulation is permitted if results are bit-identical.
- ROUND: write `sq` = accumulator >> 2*DECIMAL (rounding per Configuration), truncated to NBITS. Pulse `done`, then return to IDLE.
- Width rule: the maximum square (2^(NBITS/2) - 2^-DECIMAL)^2 rounds to below 2^NBITS, so no saturation logic is needed.
- Exact ties (fraction = 0.5) cannot occur for squares of DECIMAL-bit fractions, so there is no tie-break logic.
- `start` in CALC or ROUND is ignored. `xin` changes after acceptance have no effect.
- `start` in the cycle `done` is high is sampled in IDLE and accepted, giving back-to-back operation.
- Reset (asynchronous, any state):
  - State returns to IDLE.
  - `busy`=0, `done`=0, `sq`=0, accumulator/counter=0.
  - An in-flight operation is discarded; no `done` is produced.

## Timing
- `start` sampled at edge t0. `busy`=1 after t0. State is CALC for edges t0+1 … t0+N, ROUND at edge t0+N+1.
- At edge t0+N+1: `sq` updates, `done`=1 for exactly one cycle, `busy`=0.
- Latency is N+1 clocks, 21 at defaults. Throughput is one result per N+1 clocks.
- All outputs are registered. There is no combinational path from `start`/`xin` to outputs.

## Configuration
- Macro PSDSQUARE_ROUND_EN.
- Defined: round to nearest. `sq` = (acc + 2^(2*DECIMAL-1)) >> 2*DECIMAL.
- Undefined: truncate (floor). `sq` = acc >> 2*DECIMAL.
- Latency and handshake are identical in both builds.

## Structure
- The shared package holds:
  - the state enum (IDLE, CALC, ROUND);
  - default NBITS/DECIMAL constants;
  - derived widths N and P;
  - the rounding constant 2^(2*DECIMAL-1).
- These are shared with the square-root unit so both ends agree on the fixed-point format.
- One sub-module is natural: `psdsquare_round`, a combinational P→NBITS reducer holding the PSDSQUARE_ROUND_EN choice.
- FSM, counter and accumulator stay in the top.

## Test plan
- xin=0x030 (3.0) → after 21 clocks `done` pulses, `sq`=9 in both builds.
- xin=0x01B (1.6875; square 2.8477) → `sq`=3 with PSDSQUARE_ROUND_EN, 2 without. xin=0x028 (2.5; 6.25) → 6 in both builds.
- xin=0xFFFFF (max) → `sq`=0xFFFFE000 (exact, no overflow). xin=0 → `sq`=0, `done` still after 21 clocks.
- `start` re-asserted with a new `xin` during CALC → ignored: single `done`, result from the original operand. `start` held through `done` → second operation accepted back-to-back, second `done` 21 clocks later.
- `reset` driven low mid-CALC (asynchronous, between edges) → `busy`/`done`/`sq` go 0 immediately, no `done` afterwards. A fresh `start` after release completes normally.
